pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch-PC generator; successor of the single-redirect PC register.
- Holds the fetch PC and selects the next PC from these sources:
  - reset vector;
  - N prioritised redirect channels (EX branch, trap, etc.);
  - a direct-mapped BTB prediction;
  - sequential step.
- Sits at the head of IF. It drives fetch address and prediction info into the IF/ID pipeline register. EX trains the BTB.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC value loaded by reset.
- NUM_REDIR, 2, number of redirect channels; channel 0 has highest priority.
- BTB_ENTRIES, 16, BTB depth; power of two, at least 2.
- PC_INC, 4, sequential step in bytes.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- pc_stall, input, 1, hold PC (fetch/decode hazard).
- redir_valid, input, NUM_REDIR, per-channel redirect request.
- redir_target, input, NUM_REDIR*XLEN, packed targets; channel i occupies bits [i*XLEN +: XLEN].
- btb_upd_valid, input, 1, resolved control-flow instruction from EX.
- btb_upd_pc, input, XLEN, PC of the resolved instruction.
- btb_upd_target, input, XLEN, resolved target.
- btb_upd_taken, input, 1, resolved direction.
- pc, output, XLEN, current fetch PC (registered).
- pred_taken, output, 1, combinational BTB hit with counter >= 2 for the current pc.
- pred_target, output, XLEN, BTB target for the current pc; 0 when pred_taken=0.
- redir_misalign, output, 1, registered one-cycle pulse: the accepted redirect target had bits [1:0] != 0.

Behaviour:
- Reset:
  - pc <= RESET_VEC, redir_misalign <= 0.
  - All BTB valid bits cleared and counters set to 2'b01, in the same cycle.
  - pred_taken is therefore 0 the cycle after reset.
  - Reset asserted mid-stall or mid-redirect overrides everything.
- Next-PC priority, evaluated each posedge:
  1. rst.
  2. Lowest-index asserted redir_valid: pc <= target with bits [1:0] forced to 0. This happens even when pc_stall=1.
  3. pc_stall: pc holds.
  4. pred_taken: pc <= pred_target.
  5. Otherwise pc <= pc + PC_INC, wrapping modulo 2^XLEN; 0xFFFF_FFFC steps to 0x0000_0000.
- Latency: a redirect asserted in cycle n appears on pc in cycle n+1. No bubble is inserted by this block; flushing belongs to the pipeline control.
- redir_misalign is 1 in cycle n+1 only if the winning channel's target had low bits set. Losing channels are ignored.
- BTB index and tag:
  - idx = pc[IDXW+1:2], with IDXW = log2(BTB_ENTRIES).
  - tag = pc[XLEN-1:IDXW+2].
  - Each entry holds valid, tag, target[XLEN-1:2], and a 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- BTB update (btb_upd_valid=1):
  - Hit (valid and tag match): counter increments if taken, decrements if not, saturating at 00/11. Target is rewritten when taken.
  - Miss and taken: allocate with valid=1, new tag and target, counter=10. This evicts the previous entry.
  - Miss and not taken: no change.
- Lookup/update ordering:
  - Lookup is read-before-write: an update in cycle n is visible to lookup from cycle n+1.
  - An update and a lookup to the same index in the same cycle is legal and yields the old entry.
- Update during stall or redirect still writes the table. An update while rst=1 is dropped.

Optional Feature:
- Macro: PC_GEN_PERF_EN.
- Defined: adds outputs perf_step, perf_redir, perf_stall and perf_pred, each 32 bits.
  - Each is a free-running wrapping counter.
  - Each increments on cycles whose PC selection was, respectively, step, redirect, stall or predicted-taken.
  - Exactly one counter increments per non-reset cycle. All clear on rst.
- Undefined: these ports and registers do not exist. Functional behaviour is identical.

Decomposition:
- Package pc_gen_pkg holds:
  - default XLEN and PC_INC;
  - counter encoding constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - CTR_ALLOC (=CTR_WT);
  - a btb_entry_t typedef.
- One sub-module, pc_btb, containing the table, lookup and update logic.
- pc_gen contains the priority mux, PC register, misalign flag and perf counters.

Test Plan:
- Reset, then 3 cycles without stall: pc = 0x0, 0x4, 0x8, 0xC. pred_taken stays 0.
- Channels 0 and 1 asserted together (0x100, 0x200) with pc_stall=1: next pc=0x100 and redir_misalign=0. Repeat with channel 0 target 0x102: pc=0x100 and redir_misalign=1 for exactly one cycle.
- Train pc=0x20, taken, target 0x80, then run from 0x18:
  - pc sequence 0x18, 0x1C, 0x20, 0x80.
  - pred_taken=1 while pc=0x20.
  - Two not-taken updates at 0x20 take the counter 10→01→00, after which 0x20 steps to 0x24.
- Alias test with BTB_ENTRIES=16: taken update at 0x20 followed by taken update at 0x60 (same idx):
  - fetch at 0x20 gives pred_taken=0;
  - fetch at 0x60 predicts the new target.
- pc=0xFFFF_FFFC with no stall and no hit: next pc=0x0000_0000. Assert rst mid-stall: pc=RESET_VEC next cycle and all BTB entries report miss.
- With PC_GEN_PERF_EN: 2 step, 1 stall, 1 redirect and 1 predicted cycle give perf_step=2, perf_stall=1, perf_redir=1, perf_pred=1.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-PC generator and its BTB.
// Stored BTB fields are sized for XLEN_DEF; instances may use XLEN <= XLEN_DEF.
package pc_gen_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int PC_INC_DEF = 4;

    // 2-bit saturating direction counter
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_ALLOC = CTR_WT;

    // One BTB line: tag is zero-extended, target drops the two alignment bits
    typedef struct packed {
        logic                  valid;
        ctr_t                  ctr;
        logic [XLEN_DEF-1:0]   tag;
        logic [XLEN_DEF-1:2]   tgt;
    } btb_entry_t;

    // Which source produced the next PC in a given cycle
    typedef enum logic [1:0] {
        SEL_STEP  = 2'd0,
        SEL_REDIR = 2'd1,
        SEL_STALL = 2'd2,
        SEL_PRED  = 2'd3
    } pc_sel_t;

    // Saturating counter move toward the resolved direction
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) r = (c == CTR_ST)  ? c : ctr_t'(c + 2'd1);
        else       r = (c == CTR_SNT) ? c : ctr_t'(c - 2'd1);
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bus between the fetch-PC generator and its surroundings (pipeline control, EX, IF/ID).
// PC_GEN_PERF_EN adds the four performance counter outputs.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int NUM_REDIR = 2
);
    logic                      pc_stall;
    logic [NUM_REDIR-1:0]      redir_valid;
    logic [NUM_REDIR*XLEN-1:0] redir_target;
    logic                      btb_upd_valid;
    logic [XLEN-1:0]           btb_upd_pc;
    logic [XLEN-1:0]           btb_upd_target;
    logic                      btb_upd_taken;
    logic [XLEN-1:0]           pc;
    logic                      pred_taken;
    logic [XLEN-1:0]           pred_target;
    logic                      redir_misalign;
`ifdef PC_GEN_PERF_EN
    logic [31:0]               perf_step;
    logic [31:0]               perf_redir;
    logic [31:0]               perf_stall;
    logic [31:0]               perf_pred;

    modport master (
        output pc_stall, redir_valid, redir_target,
        output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        input  pc, pred_taken, pred_target, redir_misalign,
        input  perf_step, perf_redir, perf_stall, perf_pred
    );
    modport slave (
        input  pc_stall, redir_valid, redir_target,
        input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        output pc, pred_taken, pred_target, redir_misalign,
        output perf_step, perf_redir, perf_stall, perf_pred
    );
`else
    modport master (
        output pc_stall, redir_valid, redir_target,
        output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        input  pc, pred_taken, pred_target, redir_misalign
    );
    modport slave (
        input  pc_stall, redir_valid, redir_target,
        input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        output pc, pred_taken, pred_target, redir_misalign
    );
`endif
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with combinational lookup and EX-side training.
// Kept in flops: reset must clear every valid bit at once and the lookup is same-cycle.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] i_lookup_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:2] i_upd_pc,
    input  logic [XLEN-1:2] i_upd_target,
    input  logic            i_upd_taken
);
    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TGTW = XLEN_DEF - 2;

    btb_entry_t            w_entries [BTB_ENTRIES];
    logic [IDXW-1:0]       w_lk_idx;
    logic [IDXW-1:0]       w_up_idx;
    logic [XLEN_DEF-1:0]   w_lk_tag;
    logic [XLEN_DEF-1:0]   w_up_tag;
    btb_entry_t            w_lk_entry;
    btb_entry_t            w_up_entry;
    btb_entry_t            w_up_new;
    logic                  w_lk_hit;
    logic                  w_up_hit;
    logic                  w_up_write;

    // Lookup reads the current table contents, so a same-cycle update is not yet visible
    assign w_lk_idx      = i_lookup_pc[IDXW+1:2];
    assign w_lk_tag      = XLEN_DEF'(i_lookup_pc[XLEN-1:IDXW+2]);
    assign w_lk_entry    = w_entries[w_lk_idx];
    assign w_lk_hit      = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    assign o_pred_taken  = w_lk_hit && w_lk_entry.ctr[1];
    assign o_pred_target = o_pred_taken ? {(XLEN-2)'(w_lk_entry.tgt), 2'b00} : '0;

    assign w_up_idx   = i_upd_pc[IDXW+1:2];
    assign w_up_tag   = XLEN_DEF'(i_upd_pc[XLEN-1:IDXW+2]);
    assign w_up_entry = w_entries[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    // Training: hits move the counter (and retarget on taken); taken misses evict and allocate
    always_comb begin
        w_up_write = 1'b0;
        w_up_new   = w_up_entry;
        if (i_upd_valid) begin
            if (w_up_hit) begin
                w_up_write   = 1'b1;
                w_up_new.ctr = ctr_update(w_up_entry.ctr, i_upd_taken);
                if (i_upd_taken) begin
                    w_up_new.tgt = TGTW'(i_upd_target);
                end
            end else if (i_upd_taken) begin
                w_up_write     = 1'b1;
                w_up_new.valid = 1'b1;
                w_up_new.ctr   = CTR_ALLOC;
                w_up_new.tag   = w_up_tag;
                w_up_new.tgt   = TGTW'(i_upd_target);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            btb_entry_t r_entry;
            // Reset invalidates the line and dominates any concurrent update
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_entry.valid <= 1'b0;
                    r_entry.ctr   <= CTR_WNT;
                end else if (w_up_write && (w_up_idx == IDXW'(gi))) begin
                    r_entry <= w_up_new;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: reset vector > redirect channels > stall > BTB prediction > sequential step.
// PC_GEN_PERF_EN adds free-running counters of the selected source.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              NUM_REDIR   = 2,
    parameter int              BTB_ENTRIES = 16,
    parameter int              PC_INC      = PC_INC_DEF
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_redir_tgt;
    logic            w_redir_any;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_pred_target;
    logic [XLEN-1:0] w_tgt_arr [NUM_REDIR];
    pc_sel_t         w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REDIR; gi++) begin : g_unpack
            assign w_tgt_arr[gi] = bus.redir_target[gi*XLEN +: XLEN];
        end
    endgenerate

    // Lowest-index asserted channel wins; scanning downward leaves it as the last assignment
    always_comb begin
        w_redir_any = 1'b0;
        w_redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                w_redir_any = 1'b1;
                w_redir_tgt = w_tgt_arr[i];
            end
        end
    end

    // Next-PC source selection; a redirect is taken even while stalled
    always_comb begin
        w_sel     = SEL_STEP;
        w_pc_next = r_pc + XLEN'(PC_INC);
        if (w_redir_any) begin
            w_sel     = SEL_REDIR;
            w_pc_next = {w_redir_tgt[XLEN-1:2], 2'b00};
        end else if (bus.pc_stall) begin
            w_sel     = SEL_STALL;
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_sel     = SEL_PRED;
            w_pc_next = w_pred_target;
        end
    end

    // PC register and one-cycle misaligned-redirect flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_redir_any && (w_redir_tgt[1:0] != 2'b00);
        end
    end

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_pc   (r_pc[XLEN-1:2]),
        .o_pred_taken  (w_pred_taken),
        .o_pred_target (w_pred_target),
        .i_upd_valid   (bus.btb_upd_valid),
        .i_upd_pc      (bus.btb_upd_pc[XLEN-1:2]),
        .i_upd_target  (bus.btb_upd_target[XLEN-1:2]),
        .i_upd_taken   (bus.btb_upd_taken)
    );

    assign bus.pc             = r_pc;
    assign bus.pred_taken     = w_pred_taken;
    assign bus.pred_target    = w_pred_target;
    assign bus.redir_misalign = r_misalign;

`ifdef PC_GEN_PERF_EN
    logic [31:0] r_perf_step;
    logic [31:0] r_perf_redir;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_pred;

    // Exactly one counter advances per non-reset cycle, chosen by the PC source
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_step  <= '0;
            r_perf_redir <= '0;
            r_perf_stall <= '0;
            r_perf_pred  <= '0;
        end else begin
            case (w_sel)
                SEL_STEP:  r_perf_step  <= r_perf_step  + 32'd1;
                SEL_REDIR: r_perf_redir <= r_perf_redir + 32'd1;
                SEL_STALL: r_perf_stall <= r_perf_stall + 32'd1;
                default:   r_perf_pred  <= r_perf_pred  + 32'd1;
            endcase
        end
    end

    assign bus.perf_step  = r_perf_step;
    assign bus.perf_redir = r_perf_redir;
    assign bus.perf_stall = r_perf_stall;
    assign bus.perf_pred  = r_perf_pred;
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus a randomized run against a behavioural model.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) bus ();

    pc_gen #(
        .XLEN        (32),
        .RESET_VEC   (32'h0000_0000),
        .NUM_REDIR   (2),
        .BTB_ENTRIES (16),
        .PC_INC      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_tick = 0;

    // Behavioural model: fetch PC plus a table keyed by (pc / 4) % 16 remembering the full PC trained
    logic [31:0] m_pc;
    bit          m_mis;
    bit          m_valid [16];
    logic [31:0] m_addr  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] p_step, p_redir, p_stall, p_pred;

    function automatic void m_lookup(input logic [31:0] a, output bit taken, output logic [31:0] tgt);
        int i;
        i     = int'((a / 4) % 16);
        taken = m_valid[i] && (m_addr[i] == (a & ~32'h3)) && (m_ctr[i] >= 2);
        tgt   = taken ? m_tgt[i] : 32'h0;
    endfunction

    function automatic void model_step();
        bit          pt;
        logic [31:0] ptg;
        logic [31:0] t;
        int          win;
        int          i;
        if (rst) begin
            m_pc = 32'h0; m_mis = 0;
            for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
            p_step = 0; p_redir = 0; p_stall = 0; p_pred = 0;
            return;
        end
        m_lookup(m_pc, pt, ptg);
        win = -1;
        for (int k = 0; k < 2; k++) if (bus.redir_valid[k] && win < 0) win = k;
        if (win >= 0) begin
            t = bus.redir_target[win*32 +: 32];
            m_pc = t & ~32'h3; m_mis = (t % 4) != 0; p_redir++;
        end else begin
            m_mis = 0;
            if (bus.pc_stall) p_stall++;
            else if (pt) begin m_pc = ptg; p_pred++; end
            else begin m_pc = m_pc + 32'd4; p_step++; end
        end
        if (bus.btb_upd_valid) begin
            i = int'((bus.btb_upd_pc / 4) % 16);
            if (m_valid[i] && m_addr[i] == (bus.btb_upd_pc & ~32'h3)) begin
                if (bus.btb_upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = bus.btb_upd_target & ~32'h3;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bus.btb_upd_taken) begin
                m_valid[i] = 1; m_ctr[i] = 2;
                m_addr[i]  = bus.btb_upd_pc & ~32'h3;
                m_tgt[i]   = bus.btb_upd_target & ~32'h3;
            end
        end
    endfunction

    task automatic drive(input bit stall, input logic [1:0] rv, input logic [31:0] t0, input logic [31:0] t1,
                         input bit uv, input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
        bus.pc_stall       = stall;
        bus.redir_valid    = rv;
        bus.redir_target   = {t1, t0};
        bus.btb_upd_valid  = uv;
        bus.btb_upd_pc     = upc;
        bus.btb_upd_target = utgt;
        bus.btb_upd_taken  = utk;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        n_tick++;
        $display("cycle %0d: rst=%b stall=%b rv=%b pc=%h pred=%b ptgt=%h mis=%b",
                 n_tick, rst, bus.pc_stall, bus.redir_valid, bus.pc, bus.pred_taken, bus.pred_target, bus.redir_misalign);
    endtask

    task automatic do_reset();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", bus.pred_taken); end
        n_cmp++; if (bus.redir_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", bus.redir_misalign); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            e = 32'(4 * k);
            n_cmp++; if (bus.pc !== e) begin n_fail++; $display("FAIL step_pc: got %h want %h", bus.pc, e); end
            n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL step_pred: got %b want 0", bus.pred_taken); end
        end
    endtask

    task automatic test_redirect();
        drive(1, 2'b11, 32'h100, 32'h200, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL redir_prio_pc: got %h want %h", bus.pc, 32'h100); end
        n_cmp++; if (bus.redir_misalign !== 1'b0) begin n_fail++; $display("FAIL redir_mis0: got %b want 0", bus.redir_misalign); end
        drive(1, 2'b11, 32'h102, 32'h200, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL redir_align_pc: got %h want %h", bus.pc, 32'h100); end
        n_cmp++; if (bus.redir_misalign !== 1'b1) begin n_fail++; $display("FAIL redir_mis1: got %b want 1", bus.redir_misalign); end
        drive(1, 2'b10, 32'h0, 32'h203, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL redir_ch1_pc: got %h want %h", bus.pc, 32'h200); end
        n_cmp++; if (bus.redir_misalign !== 1'b1) begin n_fail++; $display("FAIL redir_ch1_mis: got %b want 1", bus.redir_misalign); end
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL stall_hold_pc: got %h want %h", bus.pc, 32'h200); end
        n_cmp++; if (bus.redir_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", bus.redir_misalign); end
    endtask

    task automatic test_btb_train();
        do_reset();
        drive(0, 2'b01, 32'h18, 0, 1, 32'h20, 32'h80, 1);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.pc !== 32'h18) begin n_fail++; $display("FAIL train_pc18: got %h want %h", bus.pc, 32'h18); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_pred18: got %b want 0", bus.pred_taken); end
        tick();
        n_cmp++; if (bus.pc !== 32'h1C) begin n_fail++; $display("FAIL train_pc1c: got %h want %h", bus.pc, 32'h1C); end
        tick();
        n_cmp++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL train_pc20: got %h want %h", bus.pc, 32'h20); end
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred20: got %b want 1", bus.pred_taken); end
        n_cmp++; if (bus.pred_target !== 32'h80) begin n_fail++; $display("FAIL train_tgt20: got %h want %h", bus.pred_target, 32'h80); end
        tick();
        n_cmp++; if (bus.pc !== 32'h80) begin n_fail++; $display("FAIL train_pc80: got %h want %h", bus.pc, 32'h80); end
        // two not-taken: 10 -> 01 -> 00
        drive(1, 2'b00, 0, 0, 1, 32'h20, 32'h0, 0);
        tick();
        tick();
        drive(1, 2'b01, 32'h20, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred20: got %b want 0", bus.pred_taken); end
        tick();
        n_cmp++; if (bus.pc !== 32'h24) begin n_fail++; $display("FAIL nt_pc24: got %h want %h", bus.pc, 32'h24); end
        // one taken from 00 only reaches 01: still no prediction
        drive(1, 2'b00, 0, 0, 1, 32'h20, 32'h80, 1);
        tick();
        drive(1, 2'b01, 32'h20, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_pred: got %b want 0", bus.pred_taken); end
    endtask

    task automatic test_alias();
        do_reset();
        drive(1, 2'b00, 0, 0, 1, 32'h20, 32'h40, 1);
        tick();
        drive(1, 2'b00, 0, 0, 1, 32'h60, 32'hA0, 1);
        tick();
        drive(1, 2'b01, 32'h20, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_old_pred: got %b want 0", bus.pred_taken); end
        drive(1, 2'b01, 32'h60, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_pred: got %b want 1", bus.pred_taken); end
        n_cmp++; if (bus.pred_target !== 32'hA0) begin n_fail++; $display("FAIL alias_new_tgt: got %h want %h", bus.pred_target, 32'hA0); end
        tick();
        n_cmp++; if (bus.pc !== 32'hA0) begin n_fail++; $display("FAIL alias_pc: got %h want %h", bus.pc, 32'hA0); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] a;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1, 2'b00, 0, 0, 1, 32'h1000 + 32'(4 * k), 32'h2000 + 32'(4 * k), 1);
            tick();
        end
        drive(1, 2'b01, 32'h1014, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL fill_pred: got %b want 1", bus.pred_taken); end
        drive(0, 2'b01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
        tick();
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want %h", bus.pc, 32'h0); end
        drive(1, 2'b10, 0, 32'h300, 1, 32'h0, 32'h500, 1);
        tick();
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_stall_pc: got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_drop_pred: got %b want 0", bus.pred_taken); end
        for (int k = 0; k < 16; k++) begin
            a = 32'h1000 + 32'(4 * k);
            drive(1, 2'b01, a, 0, 0, 0, 0, 0);
            tick();
            n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_clear_pred: pc=%h got %b want 0", bus.pc, bus.pred_taken); end
        end
    endtask

`ifdef PC_GEN_PERF_EN
    task automatic test_perf();
        do_reset();
        n_cmp++; if (bus.perf_step !== 32'd0) begin n_fail++; $display("FAIL perf_rst_step: got %0d want 0", bus.perf_step); end
        drive(0, 2'b00, 0, 0, 1, 32'h8, 32'h40, 1);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b01, 32'h8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL perf_pc: got %h want %h", bus.pc, 32'h40); end
        n_cmp++; if (bus.perf_step !== 32'd2) begin n_fail++; $display("FAIL perf_step: got %0d want 2", bus.perf_step); end
        n_cmp++; if (bus.perf_stall !== 32'd1) begin n_fail++; $display("FAIL perf_stall: got %0d want 1", bus.perf_stall); end
        n_cmp++; if (bus.perf_redir !== 32'd1) begin n_fail++; $display("FAIL perf_redir: got %0d want 1", bus.perf_redir); end
        n_cmp++; if (bus.perf_pred !== 32'd1) begin n_fail++; $display("FAIL perf_pred: got %0d want 1", bus.perf_pred); end
    endtask
`endif

    task automatic test_random();
        bit          et;
        logic [31:0] eg;
        logic [31:0] upc;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            upc = ($urandom % 2 == 1) ? m_pc : 32'($urandom_range(0, 63) * 4);
            upc = upc | 32'($urandom % 4);
            drive($urandom % 4 == 0,
                  {($urandom % 6 == 0), ($urandom % 6 == 0)},
                  32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                  $urandom % 2 == 1, upc, 32'($urandom_range(0, 255)), $urandom % 3 != 0);
            rst = ($urandom % 50 == 0);
            tick();
            rst = 1'b0;
            m_lookup(m_pc, et, eg);
            n_cmp++; if (bus.pc !== m_pc) begin n_fail++; $display("FAIL rand_pc: got %h want %h", bus.pc, m_pc); end
            n_cmp++; if (bus.pred_taken !== et) begin n_fail++; $display("FAIL rand_pred: pc=%h got %b want %b", bus.pc, bus.pred_taken, et); end
            n_cmp++; if (bus.pred_target !== eg) begin n_fail++; $display("FAIL rand_ptgt: pc=%h got %h want %h", bus.pc, bus.pred_target, eg); end
            n_cmp++; if (bus.redir_misalign !== m_mis) begin n_fail++; $display("FAIL rand_mis: got %b want %b", bus.redir_misalign, m_mis); end
        end
`ifdef PC_GEN_PERF_EN
        n_cmp++; if (bus.perf_step !== p_step) begin n_fail++; $display("FAIL rand_perf_step: got %0d want %0d", bus.perf_step, p_step); end
        n_cmp++; if (bus.perf_redir !== p_redir) begin n_fail++; $display("FAIL rand_perf_redir: got %0d want %0d", bus.perf_redir, p_redir); end
        n_cmp++; if (bus.perf_stall !== p_stall) begin n_fail++; $display("FAIL rand_perf_stall: got %0d want %0d", bus.perf_stall, p_stall); end
        n_cmp++; if (bus.perf_pred !== p_pred) begin n_fail++; $display("FAIL rand_perf_pred: got %0d want %0d", bus.perf_pred, p_pred); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_redirect();
        test_btb_train();
        test_alias();
        test_wrap_reset();
`ifdef PC_GEN_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
